// File: rtl/perf_sampler_pkg.sv
// Shared types and register offsets for the performance-counter sampler.
// sample_t is the widest {idx,value} record, used by software-facing views.
package perf_sampler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        READ,
        CAPTURE,
        DONE
    } sampler_state_t;

    localparam int SAMPLE_IDX_MAX_W   = 16;
    localparam int SAMPLE_VALUE_MAX_W = 32;

    typedef struct packed {
        logic [SAMPLE_IDX_MAX_W-1:0]   idx;
        logic [SAMPLE_VALUE_MAX_W-1:0] value;
    } sample_t;

    localparam logic [31:0] SEL_OFFSET  = 32'd0;
    localparam logic [31:0] DATA_OFFSET = 32'd4;

endpackage

// File: rtl/perf_counter_sampler_fifo.sv
// sample_fifo: synchronous first-word-fall-through FIFO with full/empty flags.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone define
    // which entries are valid, and a reset-free array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/perf_counter_sampler.sv
// Periodic IO-bus sweeper that snapshots performance counters into a sample FIFO.
// Define PERF_SAMPLER_DELTA_EN to report per-counter deltas instead of raw values.
module perf_counter_sampler
    import perf_sampler_pkg::*;
#(
    parameter int          NUM_COUNTERS    = 1,
    parameter int          PRFC_WIDTH      = 32,
    parameter logic [31:0] BASE_ADDRESS    = 32'd0,
    parameter int          SAMPLE_INTERVAL = 1024,
    parameter int          FIFO_DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          sweep_req,
    output logic [31:0]                   io_address,
    output logic                          io_write_en,
    output logic [31:0]                   io_write_data,
    output logic                          io_read_en,
    input  logic [31:0]                   io_read_data,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(NUM_COUNTERS):0] sample_idx,
    output logic [PRFC_WIDTH-1:0]         sample_value,
    output logic                          busy,
    output logic [15:0]                   drop_count
);

    localparam int IDX_W   = $clog2(NUM_COUNTERS) + 1;
    localparam int TMR_W   = $clog2(SAMPLE_INTERVAL);
    localparam int ENTRY_W = IDX_W + PRFC_WIDTH;

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SAMPLE_INTERVAL - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_COUNTERS - 1);
    localparam logic [31:0]      SEL_ADDR   = BASE_ADDRESS + SEL_OFFSET;
    localparam logic [31:0]      DATA_ADDR  = BASE_ADDRESS + DATA_OFFSET;

    sampler_state_t         state;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       next_idx;
    logic                   pending;
    logic [TMR_W-1:0]       timer;
    logic                   trigger;
    logic                   capture;
    logic                   drop;
    logic [PRFC_WIDTH-1:0]  raw_value;
    logic [PRFC_WIDTH-1:0]  capture_value;
    logic [ENTRY_W-1:0]     head;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Interval timer: holds while disabled, fires on the cycle it sits at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= TMR_RELOAD;
        end else if (enable) begin
            timer <= (timer == '0) ? TMR_RELOAD : timer - 1'b1;
        end
    end

    assign trigger  = sweep_req || (enable && (timer == '0));
    assign next_idx = idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            pending       <= 1'b0;
            busy          <= 1'b0;
            io_address    <= '0;
            io_write_en   <= 1'b0;
            io_write_data <= '0;
            io_read_en    <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here are overridden by later assignments
            // in the same block; the last scheduled update wins, giving one-cycle strobes.
            io_address    <= '0;
            io_write_en   <= 1'b0;
            io_write_data <= '0;
            io_read_en    <= 1'b0;
            if (trigger && (state inside {SELECT, READ, CAPTURE})) pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state       <= SELECT;
                        idx         <= '0;
                        busy        <= 1'b1;
                        io_write_en <= 1'b1;
                        io_address  <= SEL_ADDR;
                    end
                end
                SELECT: begin
                    state      <= READ;
                    io_read_en <= 1'b1;
                    io_address <= DATA_ADDR;
                end
                READ: state <= CAPTURE;
                CAPTURE: begin
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        state         <= SELECT;
                        idx           <= next_idx;
                        io_write_en   <= 1'b1;
                        io_address    <= SEL_ADDR;
                        io_write_data <= 32'(next_idx);
                    end
                end
                DONE: begin
                    // A queued request chains straight into the next sweep.
                    if (pending || trigger) begin
                        state       <= SELECT;
                        idx         <= '0;
                        pending     <= 1'b0;
                        io_write_en <= 1'b1;
                        io_address  <= SEL_ADDR;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign capture   = (state == CAPTURE);
    assign raw_value = io_read_data[PRFC_WIDTH-1:0];

`ifdef PERF_SAMPLER_DELTA_EN
    localparam int PREV_W = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;

    logic [PRFC_WIDTH-1:0] prev [NUM_COUNTERS];
    logic [PREV_W-1:0]     prev_sel;

    assign prev_sel      = idx[PREV_W-1:0];
    assign capture_value = raw_value - prev[prev_sel];

    // The baseline advances on every capture, even when the sample is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_COUNTERS; k++) prev[k] <= '0;
        end else if (capture) begin
            prev[prev_sel] <= raw_value;
        end
    end
`else
    assign capture_value = raw_value;
`endif

    sample_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (capture),
        .push_data ({idx, capture_value}),
        .pop       (sample_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A full FIFO still accepts the sample when the consumer pops in the same cycle.
    assign drop = capture && fifo_full && !sample_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 1'b1;
        end
    end

    assign sample_valid = !fifo_empty;
    assign sample_idx   = sample_valid ? head[ENTRY_W-1 -: IDX_W] : '0;
    assign sample_value = sample_valid ? head[PRFC_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_perf_counter_sampler.sv
// Randomized, model-checked bench for perf_counter_sampler (raw or delta build).
module tb_perf_counter_sampler;
    import perf_sampler_pkg::*;

    localparam int          N        = 4;
    localparam logic [31:0] BASE     = 32'h100;
    localparam int          INTERVAL = 64;
`ifdef PERF_SAMPLER_DELTA_EN
    localparam bit DELTA = 1'b1;
`else
    localparam bit DELTA = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: main sweeper. Instance B: two-entry FIFO for overflow cases.
    logic        a_enable, a_sweep_req, a_io_write_en, a_io_read_en, a_sample_valid, a_sample_ready, a_busy;
    logic [31:0] a_io_address, a_io_write_data, a_sample_value;
    logic [31:0] a_io_read_data = '0;
    logic [2:0]  a_sample_idx;
    logic [15:0] a_drop_count;
    logic        b_enable, b_sweep_req, b_io_write_en, b_io_read_en, b_sample_valid, b_sample_ready, b_busy;
    logic [31:0] b_io_address, b_io_write_data, b_sample_value;
    logic [31:0] b_io_read_data = '0;
    logic [2:0]  b_sample_idx;
    logic [15:0] b_drop_count;

    perf_counter_sampler #(.NUM_COUNTERS(N), .PRFC_WIDTH(32), .BASE_ADDRESS(BASE),
                           .SAMPLE_INTERVAL(INTERVAL), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .reset(reset), .enable(a_enable), .sweep_req(a_sweep_req),
        .io_address(a_io_address), .io_write_en(a_io_write_en), .io_write_data(a_io_write_data),
        .io_read_en(a_io_read_en), .io_read_data(a_io_read_data), .sample_valid(a_sample_valid),
        .sample_ready(a_sample_ready), .sample_idx(a_sample_idx), .sample_value(a_sample_value),
        .busy(a_busy), .drop_count(a_drop_count));

    perf_counter_sampler #(.NUM_COUNTERS(N), .PRFC_WIDTH(32), .BASE_ADDRESS(BASE),
                           .SAMPLE_INTERVAL(1024), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .reset(reset), .enable(b_enable), .sweep_req(b_sweep_req),
        .io_address(b_io_address), .io_write_en(b_io_write_en), .io_write_data(b_io_write_data),
        .io_read_en(b_io_read_en), .io_read_data(b_io_read_data), .sample_valid(b_sample_valid),
        .sample_ready(b_sample_ready), .sample_idx(b_sample_idx), .sample_value(b_sample_value),
        .busy(b_busy), .drop_count(b_drop_count));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counter devices: select register latches the index, data register returns it one cycle later.
    logic [31:0] cnt_a [N];
    logic [31:0] cnt_b [N];
    logic [31:0] sel_a = '0;
    logic [31:0] sel_b = '0;
    always @(posedge clk) begin
        if (a_io_write_en && a_io_address == BASE) sel_a <= a_io_write_data;
        if (a_io_read_en && a_io_address == BASE + 32'd4) a_io_read_data <= cnt_a[sel_a[1:0]];
        if (b_io_write_en && b_io_address == BASE) sel_b <= b_io_write_data;
        if (b_io_read_en && b_io_address == BASE + 32'd4) b_io_read_data <= cnt_b[sel_b[1:0]];
    end

    // Bus and busy monitor for instance A.
    typedef struct {
        bit          wr;
        logic [31:0] data;
        logic [31:0] addr;
        int          cyc;
    } bus_ev_t;
    bus_ev_t bus_q[$];
    int      busy_starts[$];
    int      busy_lens[$];
    int      run_len = 0;
    logic    busy_d = 1'b0;
    int      viol = 0;
    always @(negedge clk) begin
        if (a_io_write_en) bus_q.push_back('{1'b1, a_io_write_data, a_io_address, cyc});
        if (a_io_read_en)  bus_q.push_back('{1'b0, 32'd0, a_io_address, cyc});
        if (a_io_write_en && a_io_read_en) viol++;
        if (!a_busy && (a_io_write_en || a_io_read_en || a_io_address != 0 || a_io_write_data != 0)) viol++;
        if (a_busy && !busy_d) busy_starts.push_back(cyc);
        if (a_busy) run_len++;
        else if (busy_d) begin
            busy_lens.push_back(run_len);
            run_len = 0;
        end
        busy_d = a_busy;
    end

    // Reference model: every sweep produces one sample per counter, in index order.
    sample_t     exp_q[$];
    logic [31:0] got_q[$];
    logic [31:0] prev_m [N];
    sample_t     head_e;

    always @(negedge clk) begin
        if (a_sample_valid && a_sample_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_sample: observed idx=%0d expected=none", a_sample_idx);
            end
            if (exp_q.size() != 0) begin
                head_e = exp_q.pop_front();
                check("sample_idx", a_sample_idx, head_e.idx);
                check("sample_value", a_sample_value, head_e.value);
                got_q.push_back(a_sample_value);
            end
        end
    end

    task automatic expect_sweep(input bit live);
        logic [31:0] v;
        for (int i = 0; i < N; i++) begin
            v = DELTA ? cnt_a[i] - prev_m[i] : cnt_a[i];
            prev_m[i] = cnt_a[i];
            if (live || exp_q.size() < 8) exp_q.push_back('{idx: 16'(i), value: v});
        end
    endtask

    task automatic clear_logs();
        bus_q.delete();
        busy_starts.delete();
        busy_lens.delete();
        got_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) prev_m[i] = '0;
        @(posedge clk);
        #1 clear_logs();
    endtask

    task automatic pulse(input bit on_b, output int k);
        k = cyc;
        if (on_b) b_sweep_req = 1'b1; else a_sweep_req = 1'b1;
        @(posedge clk);
        #1;
        a_sweep_req = 1'b0;
        b_sweep_req = 1'b0;
    endtask

    task automatic wait_idle(input bit on_b, input int budget, input string tag);
        int   n = 0;
        logic bz;
        do begin
            @(negedge clk);
            n++;
            bz = on_b ? b_busy : a_busy;
        end while (bz && n < budget);
        check(tag, bz, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a(input string tag);
        int n = 0;
        a_sample_ready = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1 a_sample_ready = 1'b0;
        check(tag, exp_q.size(), 0);
    endtask

    task automatic pop_b();
        b_sample_ready = 1'b1;
        @(posedge clk);
        #1 b_sample_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int          k;
        int          e;
        logic [31:0] c0_old;
        logic [31:0] c0_new;

        reset = 1'b1;
        {a_enable, a_sweep_req, a_sample_ready} = '0;
        {b_enable, b_sweep_req, b_sample_ready} = '0;
        for (int i = 0; i < N; i++) begin
            cnt_a[i]  = '0;
            cnt_b[i]  = '0;
            prev_m[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {a_busy, b_busy}, 2'b00);
        check("rst_strobes", {a_io_write_en, a_io_read_en, b_io_write_en, b_io_read_en}, 4'b0);
        check("rst_bus", {a_io_address, a_io_write_data}, 64'd0);
        check("rst_fifo", {a_sample_valid, a_sample_idx, a_sample_value, b_sample_valid}, '0);
        check("rst_drops", {a_drop_count, b_drop_count}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 clear_logs();

        // One requested sweep, consumer stalled: bus order, timing and FIFO contents.
        for (int i = 0; i < N; i++) cnt_a[i] = 32'(100 + i);
        expect_sweep(1'b0);
        pulse(1'b0, k);
        wait_idle(1'b0, 40, "t1_finish");
        check("t1_nstarts", busy_starts.size(), 1);
        if (busy_starts.size() == 1) check("t1_start_cycle", busy_starts[0], k + 1);
        if (busy_lens.size() == 1) check("t1_busy_len", busy_lens[0], 13);
        check("t1_nbus", bus_q.size(), 2 * N);
        if (bus_q.size() == 2 * N) begin
            for (int i = 0; i < N; i++) begin
                check("t1_sel", {bus_q[2*i].wr, bus_q[2*i].addr, bus_q[2*i].data}, {1'b1, BASE, 32'(i)});
                check("t1_sel_cycle", bus_q[2*i].cyc, k + 1 + 3 * i);
                check("t1_rd", {bus_q[2*i+1].wr, bus_q[2*i+1].addr}, {1'b0, BASE + 32'd4});
            end
        end
        check("t1_valid", a_sample_valid, 1'b1);
        drain_a("t1_drain");
        check("t1_empty", a_sample_valid, 1'b0);

        // Timer-driven sweeps with a live consumer.
        clear_logs();
        for (int i = 0; i < N; i++) cnt_a[i] = $urandom;
        repeat (3) expect_sweep(1'b1);
        a_sample_ready = 1'b1;
        e = cyc;
        a_enable = 1'b1;
        repeat (3 * INTERVAL + 20) @(posedge clk);
        #1 a_enable = 1'b0;
        check("t2_nstarts", busy_starts.size(), 3);
        for (int j = 0; j < busy_starts.size() && j < 3; j++)
            check("t2_period", busy_starts[j], e + INTERVAL * (j + 1));
        check("t2_drops", a_drop_count, 16'd0);
        check("t2_consumed", exp_q.size(), 0);

        // Overflow on a two-entry FIFO, then push and pop in the same cycle while full.
        for (int i = 0; i < N; i++) cnt_b[i] = $urandom;
        pulse(1'b1, k);
        wait_idle(1'b1, 40, "t3_finish");
        check("t3_drops", b_drop_count, 16'd2);
        check("t3_head", {b_sample_valid, b_sample_idx, b_sample_value}, {1'b1, 3'd0, cnt_b[0]});
        c0_old = cnt_b[0];
        c0_new = $urandom;
        cnt_b[0] = c0_new;
        pulse(1'b1, k);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 b_sample_ready = 1'b1;
        @(posedge clk);
        #1 b_sample_ready = 1'b0;
        wait_idle(1'b1, 40, "t3b_finish");
        check("t3b_drops", b_drop_count, 16'd5);
        @(negedge clk);
        check("t3b_head0", {b_sample_valid, b_sample_idx, b_sample_value}, {1'b1, 3'd1, cnt_b[1]});
        pop_b();
        @(negedge clk);
        check("t3b_head1", {b_sample_valid, b_sample_idx, b_sample_value},
              {1'b1, 3'd0, DELTA ? c0_new - c0_old : c0_new});
        pop_b();
        @(negedge clk);
        check("t3b_empty", b_sample_valid, 1'b0);
        @(posedge clk);
        #1;

        // Requests while busy chain exactly one extra sweep with no idle gap.
        clear_logs();
        for (int i = 0; i < N; i++) cnt_a[i] = $urandom;
        repeat (2) expect_sweep(1'b1);
        a_sample_ready = 1'b1;
        pulse(1'b0, k);
        @(posedge clk);
        #1 pulse(1'b0, e);
        @(posedge clk);
        #1 pulse(1'b0, e);
        wait_idle(1'b0, 60, "t4_finish");
        repeat (30) @(posedge clk);
        #1 a_sample_ready = 1'b0;
        check("t4_nstarts", busy_starts.size(), 1);
        if (busy_lens.size() == 1) check("t4_busy_len", busy_lens[0], 26);
        check("t4_nbus", bus_q.size(), 4 * N);
        if (bus_q.size() == 4 * N) begin
            check("t4_second_sel", {bus_q[8].wr, bus_q[8].data}, {1'b1, 32'd0});
            check("t4_second_cycle", bus_q[8].cyc, k + 14);
        end
        check("t4_consumed", exp_q.size(), 0);

        // Reset while the data register is being read.
        clear_logs();
        pulse(1'b0, k);
        @(posedge clk);
        #1;
        check("t5_in_read", a_io_read_en, 1'b1);
        reset = 1'b1;
        #1;
        check("t5_abort", {a_io_read_en, a_io_write_en, a_busy, a_sample_valid}, 4'b0);
        check("t5_abort_bus", a_io_address, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) prev_m[i] = '0;
        @(posedge clk);
        #1 clear_logs();
        for (int i = 0; i < N; i++) cnt_a[i] = $urandom;
        expect_sweep(1'b0);
        pulse(1'b0, k);
        wait_idle(1'b0, 40, "t5_finish");
        check("t5_nbus", bus_q.size(), 2 * N);
        if (bus_q.size() != 0) check("t5_first_sel", {bus_q[0].wr, bus_q[0].data}, {1'b1, 32'd0});
        drain_a("t5_drain");
        check("t5_drops", a_drop_count, 16'd0);

        // Counter 0 reads 10, 25, then 5: raw values, or deltas with wraparound.
        do_reset();
        a_sample_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            cnt_a[0] = (s == 0) ? 32'd10 : (s == 1) ? 32'd25 : 32'd5;
            expect_sweep(1'b1);
            pulse(1'b0, k);
            wait_idle(1'b0, 40, "t6_finish");
            repeat (3) @(posedge clk);
            #1;
        end
        a_sample_ready = 1'b0;
        check("t6_count", got_q.size(), 3 * N);
        if (got_q.size() == 3 * N) begin
            check("t6_s0", got_q[0], 32'd10);
            check("t6_s1", got_q[N], DELTA ? 32'd15 : 32'd25);
            check("t6_s2", got_q[2*N], DELTA ? 32'hFFFFFFEC : 32'd5);
        end

        check("bus_protocol", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
